branch_redirect: RTL and testbench
==================================

Name: branch_redirect

Overview:
- Execute-stage producer of the PC_CHECK redirect consumed by the PC selection register.
- Resolves taken branches and jumps with MIPS delay-slot semantics: the redirect is released only after the delay-slot instruction has entered the pipe.
- Exceptions are redirected immediately, at highest priority.
- Sits between the execute stage and PC selection; also drives the fetch flush.

Parameters:
- EXC_VECTOR, 32'hBFC0_0380, exception handler target PC.
- DS_TIMEOUT, 8, max cycles spent in WAIT_DS before a forced redirect (1..255).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous reset, active-high
- stall  input  1  pipeline stall; blocks acceptance of new branch events only
- ex_valid  input  1  execute stage holds a valid instruction this cycle
- ex_is_branch  input  1  instruction is a branch/jump
- ex_taken  input  1  branch condition resolved taken (jumps: 1)
- ex_target  input  32  resolved branch target
- ds_in_pipe  input  1  delay-slot instruction of the current branch is valid in decode or later
- exc_valid  input  1  exception raised this cycle
- pc_from_execute  output  33  PC_CHECK {enable, pc_new}; enable is a one-cycle redirect pulse
- flush_if  output  1  kill the fetch-stage instruction; coincident with enable
- busy  output  1  high in WAIT_DS
- ds_timeout  output  1  sticky error: forced redirect occurred

Behaviour:
- Reset values: pc_from_execute.enable=0, pc_new=32'b0, flush_if=0, busy=0, ds_timeout=0, state=IDLE, latched target=0, wait counter=0.
- Reset during WAIT_DS discards the latched target; no redirect follows.
- All outputs are registered.
- Redirect latency: enable and flush_if assert in the cycle after the triggering condition and stay high for exactly one cycle.
- pc_new holds its last value when enable=0.
- A branch event is accepted when: ex_valid & ex_is_branch & ex_taken & !stall & state==IDLE.
- Not-taken branches never produce a redirect.
- States:
  - IDLE:
    - Accepted event with ds_in_pipe=1: redirect to ex_target next cycle; remain in IDLE.
    - Accepted event with ds_in_pipe=0: latch ex_target, clear counter, go to WAIT_DS.
  - WAIT_DS:
    - busy=1; counter increments each cycle.
    - ds_in_pipe=1: redirect to the latched target next cycle; go to IDLE.
    - Counter reaches DS_TIMEOUT-1 without ds_in_pipe: redirect anyway, set ds_timeout, go to IDLE.
    - New branch events are ignored.
    - stall does not freeze the counter or block the release.
- Exceptions:
  - exc_valid has priority over everything.
  - Redirect to EXC_VECTOR next cycle, state goes to IDLE, any latched branch target is dropped.
  - exc_valid and an accepted branch in the same cycle: the exception wins and the branch is discarded.
- The redirect pulse is issued regardless of stall, because PC selection gives execute priority over stall.
- Back-to-back accepted branches in IDLE on consecutive cycles each produce their own pulse.
- ds_timeout clears only on reset.
- Counter width is 8 bits; it cannot wrap because DS_TIMEOUT ≤ 255.

Decomposition:
- Shared defines package (existing): bool, `true/`false, PC (32-bit), PC_CHECK struct {bool enable; PC pc_new}.
- Add EXC_VECTOR_DEFAULT to the package as the parameter default.
- The state enum {IDLE, WAIT_DS} is local to the module.
- No sub-module; the wait counter is inline.

Test Plan:
- Reset held 2 cycles: all outputs 0. Then taken branch, ex_target=32'h0000_1000, ds_in_pipe=1 → next cycle enable=1, pc_new=32'h0000_1000, flush_if=1; the cycle after, enable=0.
- Taken branch, ex_target=32'h0000_2000, ds_in_pipe=0 for 3 cycles, then 1:
  - busy=1 for 3 cycles.
  - Redirect pulse to 32'h0000_2000 in the cycle after ds_in_pipe rises.
  - busy=0 afterwards.
- Not-taken branch (ex_taken=0), and a taken branch with stall=1 → enable stays 0; state remains IDLE.
- exc_valid during WAIT_DS (latched 32'h0000_3000) → next cycle pc_new=32'hBFC0_0380, enable=1. Later ds_in_pipe=1 produces no further pulse.
- DS_TIMEOUT=8, ds_in_pipe held 0 → forced redirect to the latched target 8 cycles after entry; ds_timeout=1 and stays 1 until rst.
- rst asserted mid WAIT_DS → no redirect after reset release, busy=0, pc_new=0.

Source files
------------

// File: rtl/branch_redirect_pkg.sv
// ============================================================================
// Module  : branch_redirect_pkg
// Purpose : Shared definitions for the PC redirect path. Provides the boolean
//           type and macros, the 32-bit PC type, the PC_CHECK redirect record
//           and the default exception vector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

`ifndef BRANCH_REDIRECT_BOOL_DEFINES
`define BRANCH_REDIRECT_BOOL_DEFINES
`define TRUE  1'b1
`define FALSE 1'b0
`endif

package branch_redirect_pkg;

    typedef logic        bool;
    typedef logic [31:0] PC;

    // Redirect request seen by PC selection: enable is a one-cycle pulse,
    // pc_new is the address to fetch from when enable is set.
    typedef struct packed {
        bool enable;
        PC   pc_new;
    } PC_CHECK;

    localparam PC EXC_VECTOR_DEFAULT = 32'hBFC0_0380;

endpackage : branch_redirect_pkg

`default_nettype wire

// File: rtl/branch_redirect.sv
// ============================================================================
// Module  : branch_redirect
// Purpose : Execute-stage redirect producer. Resolves taken branches/jumps
//           with delay-slot semantics (redirect only once the delay-slot
//           instruction is in the pipe) and redirects exceptions immediately.
// Ports   : clk, rst            - clock, synchronous active-high reset
//           stall               - blocks acceptance of new branch events
//           ex_valid/ex_is_branch/ex_taken/ex_target - resolved branch info
//           ds_in_pipe          - delay slot of current branch is in the pipe
//           exc_valid           - exception raised this cycle
//           pc_from_execute     - {enable, pc_new} redirect to PC selection
//           flush_if            - kill fetch-stage instruction (with enable)
//           busy                - waiting for the delay slot
//           ds_timeout          - sticky: a forced redirect occurred
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module branch_redirect
    import branch_redirect_pkg::*;
#(
    parameter PC  EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int DS_TIMEOUT = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        ex_valid,
    input  logic        ex_is_branch,
    input  logic        ex_taken,
    input  logic [31:0] ex_target,
    input  logic        ds_in_pipe,
    input  logic        exc_valid,
    output PC_CHECK     pc_from_execute,
    output logic        flush_if,
    output logic        busy,
    output logic        ds_timeout
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        WAIT_DS = 1'b1
    } state_t;

    localparam logic [7:0] c_CNT_LAST = 8'(DS_TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    PC          tgt_q,   tgt_d;
    bool        en_q,    en_d;
    PC          pc_q,    pc_d;
    bool        to_q,    to_d;

    logic       w_accept;

    // State qualification (IDLE) is applied inside the FSM.
    assign w_accept = ex_valid & ex_is_branch & ex_taken & ~stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            tgt_q   <= 32'd0;
            en_q    <= `FALSE;
            pc_q    <= 32'd0;
            to_q    <= `FALSE;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tgt_q   <= tgt_d;
            en_q    <= en_d;
            pc_q    <= pc_d;
            to_q    <= to_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        tgt_d   = tgt_q;
        en_d    = `FALSE;
        pc_d    = pc_q;
        to_d    = to_q;

        if (exc_valid) begin
            // Exception overrides any pending or same-cycle branch.
            en_d    = `TRUE;
            pc_d    = EXC_VECTOR;
            state_d = IDLE;
            tgt_d   = 32'd0;
            cnt_d   = 8'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_accept) begin
                        if (ds_in_pipe) begin
                            en_d = `TRUE;
                            pc_d = ex_target;
                        end else begin
                            tgt_d   = ex_target;
                            cnt_d   = 8'd0;
                            state_d = WAIT_DS;
                        end
                    end
                end
                WAIT_DS: begin
                    // Stall is intentionally ignored here: release must not
                    // be held off once the delay slot has entered the pipe.
                    if (ds_in_pipe) begin
                        en_d    = `TRUE;
                        pc_d    = tgt_q;
                        state_d = IDLE;
                    end else if (cnt_q == c_CNT_LAST) begin
                        en_d    = `TRUE;
                        pc_d    = tgt_q;
                        to_d    = `TRUE;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign pc_from_execute.enable = en_q;
    assign pc_from_execute.pc_new = pc_q;
    assign flush_if               = en_q;
    assign busy                   = (state_q == WAIT_DS);
    assign ds_timeout             = to_q;

endmodule : branch_redirect

`default_nettype wire

// File: tb/tb_branch_redirect.sv
// ============================================================================
// Module  : tb_branch_redirect
// Purpose : Directed self-checking bench for branch_redirect.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_branch_redirect;
    import branch_redirect_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        ex_valid;
    logic        ex_is_branch;
    logic        ex_taken;
    logic [31:0] ex_target;
    logic        ds_in_pipe;
    logic        exc_valid;
    PC_CHECK     pc_from_execute;
    logic        flush_if;
    logic        busy;
    logic        ds_timeout;

    int checks = 0;
    int errors = 0;

    branch_redirect #(
        .EXC_VECTOR (32'hBFC0_0380),
        .DS_TIMEOUT (8)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .ex_valid        (ex_valid),
        .ex_is_branch    (ex_is_branch),
        .ex_taken        (ex_taken),
        .ex_target       (ex_target),
        .ds_in_pipe      (ds_in_pipe),
        .exc_valid       (exc_valid),
        .pc_from_execute (pc_from_execute),
        .flush_if        (flush_if),
        .busy            (busy),
        .ds_timeout      (ds_timeout)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Checks the full output set at once.
    task automatic chk_all(input string tag, input logic en, input logic [31:0] pc,
                           input logic bsy, input logic to);
        chk({tag, ".enable"},  {31'd0, pc_from_execute.enable}, {31'd0, en});
        chk({tag, ".pc_new"},  pc_from_execute.pc_new, pc);
        chk({tag, ".flush_if"}, {31'd0, flush_if}, {31'd0, en});
        chk({tag, ".busy"},    {31'd0, busy}, {31'd0, bsy});
        chk({tag, ".ds_timeout"}, {31'd0, ds_timeout}, {31'd0, to});
    endtask

    task automatic idle_inputs();
        stall = 0; ex_valid = 0; ex_is_branch = 0; ex_taken = 0;
        ex_target = 32'd0; ds_in_pipe = 0; exc_valid = 0;
    endtask

    task automatic branch(input logic [31:0] tgt, input logic ds);
        ex_valid = 1; ex_is_branch = 1; ex_taken = 1; ex_target = tgt; ds_in_pipe = ds;
    endtask

    initial begin
        idle_inputs();
        rst = 1;
        tick(); tick();
        chk_all("reset", 0, 32'h0, 0, 0);
        rst = 0;

        // Taken branch with delay slot already in pipe
        branch(32'h0000_1000, 1);
        tick();
        chk_all("br_ds1", 1, 32'h0000_1000, 0, 0);
        idle_inputs();
        tick();
        chk_all("br_ds1_after", 0, 32'h0000_1000, 0, 0);

        // Taken branch waiting for the delay slot
        branch(32'h0000_2000, 0);
        tick();
        chk_all("wait_w1", 0, 32'h0000_1000, 1, 0);
        idle_inputs();
        tick();
        chk_all("wait_w2", 0, 32'h0000_1000, 1, 0);
        tick();
        chk_all("wait_w3", 0, 32'h0000_1000, 1, 0);
        ds_in_pipe = 1;
        tick();
        chk_all("wait_release", 1, 32'h0000_2000, 0, 0);
        ds_in_pipe = 0;
        tick();
        chk_all("wait_after", 0, 32'h0000_2000, 0, 0);

        // Not-taken branch and stalled taken branch
        branch(32'hDEAD_0000, 1); ex_taken = 0;
        tick();
        chk_all("not_taken", 0, 32'h0000_2000, 0, 0);
        branch(32'hDEAD_1000, 1); stall = 1;
        tick();
        chk_all("stalled_ds1", 0, 32'h0000_2000, 0, 0);
        branch(32'hDEAD_2000, 0); stall = 1;
        tick();
        chk_all("stalled_ds0", 0, 32'h0000_2000, 0, 0);
        idle_inputs();

        // Exception during WAIT_DS
        branch(32'h0000_3000, 0);
        tick();
        chk_all("exc_wait_w1", 0, 32'h0000_2000, 1, 0);
        idle_inputs();
        tick();
        chk_all("exc_wait_w2", 0, 32'h0000_2000, 1, 0);
        exc_valid = 1;
        tick();
        chk_all("exc_redirect", 1, 32'hBFC0_0380, 0, 0);
        exc_valid = 0; ds_in_pipe = 1;
        tick();
        chk_all("exc_ds_late1", 0, 32'hBFC0_0380, 0, 0);
        tick();
        chk_all("exc_ds_late2", 0, 32'hBFC0_0380, 0, 0);
        idle_inputs();

        // Exception and accepted branch in the same cycle
        branch(32'h0000_4000, 1); exc_valid = 1;
        tick();
        chk_all("exc_vs_branch", 1, 32'hBFC0_0380, 0, 0);
        idle_inputs();

        // Back-to-back accepted branches
        branch(32'h0000_5000, 1);
        tick();
        chk_all("b2b_first", 1, 32'h0000_5000, 0, 0);
        branch(32'h0000_6000, 1);
        tick();
        chk_all("b2b_second", 1, 32'h0000_6000, 0, 0);
        idle_inputs();
        tick();
        chk_all("b2b_after", 0, 32'h0000_6000, 0, 0);

        // Delay-slot timeout: forced redirect 8 cycles after entry
        branch(32'h0000_7000, 0);
        tick();
        chk_all("to_entry", 0, 32'h0000_6000, 1, 0);
        idle_inputs();
        for (int k = 1; k <= 7; k++) begin
            // A new taken branch while waiting must be ignored.
            if (k == 3) branch(32'h0000_9999, 0);
            tick();
            idle_inputs();
            chk_all($sformatf("to_wait%0d", k), 0, 32'h0000_6000, 1, 0);
        end
        tick();
        chk_all("to_forced", 1, 32'h0000_7000, 0, 1);
        tick();
        chk_all("to_sticky1", 0, 32'h0000_7000, 0, 1);
        tick();
        chk_all("to_sticky2", 0, 32'h0000_7000, 0, 1);

        // Reset in the middle of WAIT_DS
        branch(32'h0000_8000, 0);
        tick();
        chk_all("rst_wait", 0, 32'h0000_7000, 1, 1);
        idle_inputs();
        tick();
        rst = 1;
        tick();
        rst = 0;
        chk_all("rst_mid", 0, 32'h0, 0, 0);
        ds_in_pipe = 1;
        tick();
        chk_all("rst_no_redirect1", 0, 32'h0, 0, 0);
        tick();
        chk_all("rst_no_redirect2", 0, 32'h0, 0, 0);
        idle_inputs();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_branch_redirect

`default_nettype wire
